keypad_scan4x4: RTL and testbench

- Input-side counterpart of the scanned 7-segment display driver.
- Drives the rows of a 4x4 matrix keypad one at a time with active-low strobes, and senses the four active-low columns.
- Debounces both press and release, then latches a 4-bit key code into a CPU-readable status word.
- Sits on the CPU peripheral bus beside the display driver and is selected by cs.

---
 rtl/keypad_scan4x4.sv | 242 ++++++++++++++++++++++++
 tb/tb_keypad_scan4x4.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan4x4.sv
// Purpose: 4x4 matrix keypad scanner; debounces press and release and latches a key code into a CPU status word.
// Latency: key latched <= (4+DEBOUNCE_CNT)*2^SCAN_DIV_W+3 clk after columns settle; o_data is combinational from registers.
// Backpressure: none; an unread key is overwritten and flagged as overrun. Define KEYPAD_IRQ_EN to add the o_irq output.
module keypad_scan4x4 #(
    parameter int SCAN_DIV_W   = 6,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        rd,
    input  logic [3:0]  i_col,
    output logic [3:0]  o_row,
    output logic [31:0] o_data
`ifdef KEYPAD_IRQ_EN
    ,
    output logic        o_irq
`endif
);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0]            DEB_TGT = 4'(DEBOUNCE_CNT);
    localparam logic [SCAN_DIV_W-1:0] DIV_ONE = SCAN_DIV_W'(1);

    // Exactly one column pulled low; anything else (idle or ghosting) is no key.
    function automatic logic is_single(input logic [3:0] c);
        case (c)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: is_single = 1'b1;
            default:                            is_single = 1'b0;
        endcase
    endfunction

    // Index of the low bit of a single-low column pattern.
    function automatic logic [1:0] col_index(input logic [3:0] c);
        case (c)
            4'b1101: col_index = 2'd1;
            4'b1011: col_index = 2'd2;
            4'b0111: col_index = 2'd3;
            default: col_index = 2'd0;
        endcase
    endfunction

    // Synchronizer and scan registers
    logic [3:0]            sync1_q;
    logic [3:0]            col_s_q;
    logic [SCAN_DIV_W-1:0] div_q;
    logic                  tick;

    // FSM registers
    state_t     state_q,   state_d;
    logic [1:0] row_idx_q, row_idx_d;
    logic [3:0] deb_cnt_q, deb_cnt_d;
    logic [3:0] deb_inc;
    logic [3:0] cap_col_q, cap_col_d;
    logic [1:0] cap_row_q, cap_row_d;
    logic [3:0] row_q;

    // HELD-entry event from the FSM to the status word
    logic       held_entry;
    logic [3:0] entry_code;

    // Status word registers
    logic       rd_hit;
    logic       valid_q,     valid_d;
    logic       overrun_q,   overrun_d;
    logic [7:0] press_cnt_q, press_cnt_d;
    logic [3:0] keycode_q,   keycode_d;

    assign tick    = &div_q;
    assign deb_inc = deb_cnt_q + 4'd1;
    assign rd_hit  = cs & rd;

    // Two-flop synchronizer for the asynchronous, active-low columns.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 4'hF;
            col_s_q <= 4'hF;
        end else begin
            sync1_q <= i_col;
            col_s_q <= sync1_q;
        end
    end

    // Free-running divider; its all-ones cycle is the scan tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_ONE;
        end
    end

    // FSM state, row index, debounce counter, captured key and row strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_SCAN;
            row_idx_q <= 2'd0;
            deb_cnt_q <= 4'd0;
            cap_col_q <= 4'hF;
            cap_row_q <= 2'd0;
            row_q     <= 4'b1110;
        end else begin
            state_q   <= state_d;
            row_idx_q <= row_idx_d;
            deb_cnt_q <= deb_cnt_d;
            cap_col_q <= cap_col_d;
            cap_row_q <= cap_row_d;
            // Decoded from the next index so the strobe and row_idx stay aligned.
            row_q     <= ~(4'b0001 << row_idx_d);
        end
    end

    // Next-state logic; every decision waits for a scan tick.
    always_comb begin
        state_d    = state_q;
        row_idx_d  = row_idx_q;
        deb_cnt_d  = deb_cnt_q;
        cap_col_d  = cap_col_q;
        cap_row_d  = cap_row_q;
        held_entry = 1'b0;
        entry_code = {cap_row_q, col_index(cap_col_q)};
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (is_single(col_s_q)) begin
                        cap_col_d = col_s_q;
                        cap_row_d = row_idx_q;
                        deb_cnt_d = 4'd1;
                        if (DEB_TGT == 4'd1) begin
                            // A single sample is enough: latch straight away.
                            held_entry = 1'b1;
                            entry_code = {row_idx_q, col_index(col_s_q)};
                            state_d    = ST_HELD;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (col_s_q == cap_col_q) begin
                        deb_cnt_d = deb_inc;
                        if (deb_inc == DEB_TGT) begin
                            held_entry = 1'b1;
                            state_d    = ST_HELD;
                        end
                    end else begin
                        // Bounce: drop the candidate and move on to the next row.
                        row_idx_d = row_idx_q + 2'd1;
                        state_d   = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    if (col_s_q == 4'hF) begin
                        deb_cnt_d = 4'd1;
                        if (DEB_TGT == 4'd1) begin
                            row_idx_d = row_idx_q + 2'd1;
                            state_d   = ST_SCAN;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (col_s_q == 4'hF) begin
                        deb_cnt_d = deb_inc;
                        if (deb_inc == DEB_TGT) begin
                            row_idx_d = row_idx_q + 2'd1;
                            state_d   = ST_SCAN;
                        end
                    end else begin
                        // Release bounced: the key is still down.
                        state_d = ST_HELD;
                    end
                end
                default: begin
                    state_d = ST_SCAN;
                end
            endcase
        end
    end

    // Status word update: a read clears the flags, a new key overrides the read.
    always_comb begin
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        press_cnt_d = press_cnt_q;
        keycode_d   = keycode_q;
        if (rd_hit) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
        if (held_entry) begin
            valid_d     = 1'b1;
            keycode_d   = entry_code;
            press_cnt_d = press_cnt_q + 8'd1;
            // The old word was read this cycle, so nothing was lost.
            overrun_d   = rd_hit ? overrun_q : (overrun_q | valid_q);
        end
    end

    // Status word registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            press_cnt_q <= 8'd0;
            keycode_q   <= 4'd0;
        end else begin
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            press_cnt_q <= press_cnt_d;
            keycode_q   <= keycode_d;
        end
    end

`ifdef KEYPAD_IRQ_EN
    logic irq_q;

    // Interrupt mirrors valid as a registered output.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= valid_d;
        end
    end

    assign o_irq = irq_q;
`endif

    assign o_row  = row_q;
    assign o_data = {valid_q, overrun_q, 14'd0, press_cnt_q, 4'd0, keycode_q};

endmodule

// File: tb/tb_keypad_scan4x4.sv
// Purpose: directed bench for keypad_scan4x4 with a behavioural keypad model.
// Latency: runs with SCAN_DIV_W=2 (tick every 4 clk) and DEBOUNCE_CNT=3.
// Backpressure: n/a; inputs driven and outputs sampled on the falling edge.
module tb_keypad_scan4x4;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        cs    = 1'b0;
    logic        rd    = 1'b0;
    logic [3:0]  i_col;
    logic [3:0]  o_row;
    logic [31:0] o_data;
`ifdef KEYPAD_IRQ_EN
    logic        o_irq;
`endif

    // Keypad model: a pressed key pulls its column low only while its row is strobed.
    logic       key_en    = 1'b0;
    logic [1:0] key_row   = 2'd0;
    logic [1:0] key_col   = 2'd0;
    logic       force_en  = 1'b0;
    logic [3:0] force_val = 4'hF;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    assign i_col = force_en ? force_val :
                   ((key_en && (o_row == ~(4'b0001 << key_row))) ? ~(4'b0001 << key_col) : 4'hF);

    keypad_scan4x4 #(
        .SCAN_DIV_W   (2),
        .DEBOUNCE_CNT (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .cs     (cs),
        .rd     (rd),
        .i_col  (i_col),
        .o_row  (o_row),
        .o_data (o_data)
`ifdef KEYPAD_IRQ_EN
        ,
        .o_irq  (o_irq)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_row(input logic [3:0] r, input bit want_eq, input int limit, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if ((o_row == r) == want_eq) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_data(input logic [31:0] mask, input logic [31:0] val, input int limit, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if ((o_data & mask) == val) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        logic [3:0] e;
        logic [3:0] r;

        // Reset state and idle scan pattern
        do_reset();
        chk("rst_row", 32'(o_row), 32'h0000_000E);
        chk("rst_data", o_data, 32'h0000_0000);
`ifdef KEYPAD_IRQ_EN
        chk("rst_irq", 32'(o_irq), 32'd0);
`endif
        for (int k = 0; k < 64; k++) begin
            e = ~(4'b0001 << ((k / 4) % 4));
            chk("idle_row", 32'(o_row), 32'(e));
            @(negedge clk);
        end
        chk("idle_data", o_data, 32'h0000_0000);

        // Row2/col1 press
        key_row = 2'd2;
        key_col = 2'd1;
        key_en  = 1'b1;
        wait_data(32'h8000_0000, 32'h8000_0000, 400, "wait_k9");
        chk("k9_word", o_data, 32'h8000_0109);
        chk("k9_row", 32'(o_row), 32'h0000_000B);
        repeat (20) @(negedge clk);
        chk("k9_hold_row", 32'(o_row), 32'h0000_000B);
        chk("k9_norepeat", o_data, 32'h8000_0109);
`ifdef KEYPAD_IRQ_EN
        chk("k9_irq", 32'(o_irq), 32'd1);
`endif

        // Bounce on row0, then a stable row0/col3 press
        key_en = 1'b0;
        do_reset();
        wait_row(4'b1110, 1'b0, 40, "wait_leave_r0");
        wait_row(4'b1110, 1'b1, 40, "wait_enter_r0");
        force_val = 4'b0111;
        force_en  = 1'b1;
        repeat (2) @(negedge clk);
        force_en  = 1'b0;
        repeat (3) @(negedge clk);
        chk("bounce_frozen", 32'(o_row), 32'h0000_000E);
        repeat (4) @(negedge clk);
        chk("bounce_reject", 32'(o_row), 32'h0000_000D);
        chk("bounce_nolatch", o_data, 32'h0000_0000);
        key_row = 2'd0;
        key_col = 2'd3;
        key_en  = 1'b1;
        wait_data(32'h8000_0000, 32'h8000_0000, 400, "wait_k3");
        chk("k3_word", o_data, 32'h8000_0103);

        // Release, then row1/col0 without reading first -> overrun
        key_en = 1'b0;
        repeat (40) @(negedge clk);
        chk("rel_keep", o_data, 32'h8000_0103);
        key_row = 2'd1;
        key_col = 2'd0;
        key_en  = 1'b1;
        wait_data(32'h8000_000F, 32'h8000_0004, 400, "wait_k4");
        chk("k4_word", o_data, 32'hC000_0204);

        // CPU read clears valid and overrun on the next edge
        cs = 1'b1;
        rd = 1'b1;
        chk("rd_word", o_data, 32'hC000_0204);
        @(negedge clk);
        cs = 1'b0;
        rd = 1'b0;
        chk("rd_clear", o_data, 32'h0000_0204);
`ifdef KEYPAD_IRQ_EN
        chk("rd_irq", 32'(o_irq), 32'd0);
`endif

        // Read lands on the HELD-entry cycle of row3/col2 (11 cycles after the strobe)
        key_en = 1'b0;
        repeat (40) @(negedge clk);
        key_row = 2'd3;
        key_col = 2'd2;
        wait_row(4'b0111, 1'b0, 40, "wait_leave_r3");
        wait_row(4'b0111, 1'b1, 40, "wait_enter_r3");
        key_en = 1'b1;
        repeat (11) @(negedge clk);
        cs = 1'b1;
        rd = 1'b1;
        @(negedge clk);
        cs = 1'b0;
        rd = 1'b0;
        chk("coinc_word", o_data, 32'h8000_030E);
`ifdef KEYPAD_IRQ_EN
        chk("coinc_irq", 32'(o_irq), 32'd1);
`endif

        // Reset while HELD
        chk("held_row3", 32'(o_row), 32'h0000_0007);
        reset  = 1'b1;
        key_en = 1'b0;
        @(negedge clk);
        chk("hrst_row", 32'(o_row), 32'h0000_000E);
        chk("hrst_data", o_data, 32'h0000_0000);
`ifdef KEYPAD_IRQ_EN
        chk("hrst_irq", 32'(o_irq), 32'd0);
`endif
        reset = 1'b0;

        // Two columns low: no key, scanning continues
        force_val = 4'b1100;
        force_en  = 1'b1;
        r = o_row;
        e = {r[2:0], r[3]};
        repeat (4) @(negedge clk);
        chk("dual_scan", 32'(o_row), 32'(e));
        repeat (60) @(negedge clk);
        chk("dual_nokey", o_data, 32'h0000_0000);
        r = o_row;
        e = {r[2:0], r[3]};
        repeat (4) @(negedge clk);
        chk("dual_scan2", 32'(o_row), 32'(e));
        force_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
